// File: rtl/lower_layer_n_sort.sv
// lower_layer_n_sort
// Loads NUM_IN unsigned distances in one cycle, sorts them in place with an
// odd-even transposition network (one phase per clock) and streams the K
// smallest values out in ascending order, each tagged with its original input
// index, over a valid/ready handshake.
//
// Optional build macro: LOWER_SORT_EARLY_EXIT_EN
//   When defined, the sort leaves early once two consecutive phases make no
//   swap (minimum two phases). When undefined, the sort always runs NUM_IN
//   phases.
module lower_layer_n_sort #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_IN     = 4,
    parameter int K          = NUM_IN,
    parameter int IDX_W      = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        sorted_data,
    output logic [IDX_W-1:0]             sorted_idx,
    output logic                         done
);

    localparam int PH_W = $clog2(NUM_IN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SORT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] val_q [NUM_IN];
    logic [DATA_WIDTH-1:0] val_d [NUM_IN];
    logic [IDX_W-1:0]      tag_q [NUM_IN];
    logic [IDX_W-1:0]      tag_d [NUM_IN];

    // One compare-exchange decision per adjacent pair; only pairs whose lower
    // position has the same parity as the current phase take part.
    logic [NUM_IN-2:0]     pair_swap;

`ifdef LOWER_SORT_EARLY_EXIT_EN
    logic                  any_swap;
    logic                  prev_swap_q, prev_swap_d;
`endif

    generate
        for (genvar gi = 0; gi < NUM_IN - 1; gi++) begin : g_pair
            localparam logic PAIR_PARITY = logic'(gi % 2);
            // Strict compare keeps equal values in place, so ties stay in
            // ascending input-index order.
            assign pair_swap[gi] = (ph_q[0] == PAIR_PARITY) &&
                                   (val_q[gi] > val_q[gi+1]);
        end
    endgenerate

`ifdef LOWER_SORT_EARLY_EXIT_EN
    assign any_swap = |pair_swap;
`endif

    // Value/tag array next state: capture on load, compare-exchange while sorting.
    always_comb begin
        val_d = val_q;
        tag_d = tag_q;
        if (state_q == S_IDLE && load) begin
            for (int i = 0; i < NUM_IN; i++) begin
                val_d[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
                tag_d[i] = IDX_W'(i);
            end
        end else if (state_q == S_SORT) begin
            for (int j = 0; j < NUM_IN - 1; j++) begin
                if (pair_swap[j]) begin
                    val_d[j]   = val_q[j+1];
                    val_d[j+1] = val_q[j];
                    tag_d[j]   = tag_q[j+1];
                    tag_d[j+1] = tag_q[j];
                end
            end
        end
    end

    // Array storage; contents are meaningless outside a batch, so no reset.
    always_ff @(posedge clk) begin
        val_q <= val_d;
        tag_q <= tag_d;
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ph_q        <= '0;
            ptr_q       <= '0;
            done_q      <= 1'b0;
`ifdef LOWER_SORT_EARLY_EXIT_EN
            prev_swap_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            ptr_q       <= ptr_d;
            done_q      <= done_d;
`ifdef LOWER_SORT_EARLY_EXIT_EN
            prev_swap_q <= prev_swap_d;
`endif
        end
    end

    // FSM next-state logic and outputs.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        ptr_d       = ptr_q;
        done_d      = 1'b0;
`ifdef LOWER_SORT_EARLY_EXIT_EN
        prev_swap_d = prev_swap_q;
`endif
        busy        = (state_q != S_IDLE);
        out_valid   = 1'b0;
        done        = done_q;
        sorted_data = '0;
        sorted_idx  = '0;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d     = S_SORT;
                    ph_d        = '0;
`ifdef LOWER_SORT_EARLY_EXIT_EN
                    prev_swap_d = 1'b0;
`endif
                end
            end
            S_SORT: begin
                ph_d = ph_q + PH_W'(1);
`ifdef LOWER_SORT_EARLY_EXIT_EN
                prev_swap_d = any_swap;
`endif
                if (ph_q == PH_W'(NUM_IN - 1)) begin
                    state_d = S_OUT;
                    ptr_d   = '0;
                end
`ifdef LOWER_SORT_EARLY_EXIT_EN
                // Two quiet phases in a row cover both parities: array is sorted.
                else if (!any_swap && !prev_swap_q && ph_q != '0) begin
                    state_d = S_OUT;
                    ptr_d   = '0;
                end
`endif
            end
            S_OUT: begin
                out_valid   = 1'b1;
                sorted_data = val_q[ptr_q];
                sorted_idx  = tag_q[ptr_q];
                if (out_ready) begin
                    if (ptr_q == IDX_W'(K - 1)) begin
                        state_d = S_IDLE;
                        ptr_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lower_layer_n_sort.sv
// Testbench for lower_layer_n_sort: table vectors, hand sequences for
// backpressure / reset / top-K, and randomized batches against a stable
// selection-sort reference.
module tb_lower_layer_n_sort;

    localparam int DW = 8;
    localparam int N  = 4;
`ifdef LOWER_SORT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, load, out_ready;
    logic [N*DW-1:0] data_in;
    logic            busy, out_valid, done;
    logic [DW-1:0]   sorted_data;
    logic [1:0]      sorted_idx;

    logic            load2, ready2;
    logic [N*DW-1:0] data2;
    logic            busy2, valid2, done2;
    logic [DW-1:0]   sd2;
    logic [1:0]      si2;

    lower_layer_n_sort #(.DATA_WIDTH(DW), .NUM_IN(N), .K(N)) u_dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .sorted_data(sorted_data), .sorted_idx(sorted_idx), .done(done)
    );

    lower_layer_n_sort #(.DATA_WIDTH(DW), .NUM_IN(N), .K(2)) u_k2 (
        .clk(clk), .rst(rst), .load(load2), .data_in(data2),
        .busy(busy2), .out_valid(valid2), .out_ready(ready2),
        .sorted_data(sd2), .sorted_idx(si2), .done(done2)
    );

    typedef logic [N-1:0][DW-1:0] dvec_t;
    typedef logic [N-1:0][1:0]    ivec_t;

    typedef struct packed {
        dvec_t din;
        dvec_t ed;
        ivec_t ei;
        int    lat;   // 0: no exact latency expectation
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic dvec_t pk(input int a0, input int a1, input int a2, input int a3);
        dvec_t r;
        r[0] = DW'(a0); r[1] = DW'(a1); r[2] = DW'(a2); r[3] = DW'(a3);
        return r;
    endfunction

    function automatic ivec_t pki(input int a0, input int a1, input int a2, input int a3);
        ivec_t r;
        r[0] = 2'(a0); r[1] = 2'(a1); r[2] = 2'(a2); r[3] = 2'(a3);
        return r;
    endfunction

    // Reference: repeatedly pick the smallest unused value, lowest index on ties.
    task automatic ref_sort(input dvec_t din, output dvec_t ed, output ivec_t ei);
        bit used [N];
        for (int i = 0; i < N; i++) used[i] = 1'b0;
        for (int p = 0; p < N; p++) begin
            int best;
            best = -1;
            for (int i = 0; i < N; i++)
                if (!used[i] && (best < 0 || din[i] < din[best])) best = i;
            used[best] = 1'b1;
            ed[p] = din[best];
            ei[p] = 2'(best);
        end
    endtask

    // Load one batch (load asserted in the current cycle) and drain it.
    task automatic run_batch(input vec_t v, input bit stall);
        int lat;
        data_in = v.din;
        load    = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        check("busy_after_load", 32'(busy), 1);
        check("done_low_after_load", 32'(done), 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            check("out_valid_timeout", 0, 1);
            return;
        end
        if (v.lat != 0)      check("latency", 32'(lat), 32'(v.lat));
        else if (!EE)        check("latency", 32'(lat), N);
        else                 check("latency_range", 32'(lat >= 2 && lat <= N), 1);
        for (int p = 0; p < N; p++) begin
            int s;
            s = stall ? int'($urandom_range(0, 2)) : 0;
            out_ready = 1'b0;
            for (int c = 0; c < s; c++) begin
                check("stall_data", 32'(sorted_data), 32'(v.ed[p]));
                check("stall_idx", 32'(sorted_idx), 32'(v.ei[p]));
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            check("valid", 32'(out_valid), 1);
            check("data", 32'(sorted_data), 32'(v.ed[p]));
            check("idx", 32'(sorted_idx), 32'(v.ei[p]));
            $display("batch elem %0d: data=%0d idx=%0d (exp %0d/%0d)", p, sorted_data, sorted_idx, v.ed[p], v.ei[p]);
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        check("done_pulse", 32'(done), 1);
        check("valid_after_done", 32'(out_valid), 0);
        check("busy_after_done", 32'(busy), 0);
    endtask

    vec_t tbl [5];

    initial begin
        vec_t v;
        int   w;

        tbl[0].din = pk(5, 3, 9, 1);       tbl[0].ed = pk(1, 3, 5, 9);
        tbl[0].ei  = pki(3, 1, 0, 2);      tbl[0].lat = 4;
        tbl[1].din = pk(7, 7, 2, 7);       tbl[1].ed = pk(2, 7, 7, 7);
        tbl[1].ei  = pki(2, 0, 1, 3);      tbl[1].lat = 4;
        tbl[2].din = pk(4, 3, 2, 1);       tbl[2].ed = pk(1, 2, 3, 4);
        tbl[2].ei  = pki(3, 2, 1, 0);      tbl[2].lat = 4;
        tbl[3].din = pk(1, 2, 3, 4);       tbl[3].ed = pk(1, 2, 3, 4);
        tbl[3].ei  = pki(0, 1, 2, 3);      tbl[3].lat = EE ? 2 : 4;
        tbl[4].din = pk(255, 0, 255, 0);   tbl[4].ed = pk(0, 0, 255, 255);
        tbl[4].ei  = pki(1, 3, 0, 2);      tbl[4].lat = 4;

        rst = 1'b1; load = 1'b0; out_ready = 1'b0; data_in = '0;
        load2 = 1'b0; ready2 = 1'b1; data2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_data", 32'(sorted_data), 0);
        check("rst_idx", 32'(sorted_idx), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table vectors, back-to-back: each load lands on the previous done cycle.
        for (int i = 0; i < 5; i++) run_batch(tbl[i], 1'b0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 0);

        // Backpressure with loads pulsed during SORT and OUT (must be ignored).
        data_in = pk(5, 3, 9, 1); load = 1'b1;
        @(posedge clk); #1;
        data_in = pk(0, 0, 0, 0);      // load stays high during SORT
        w = 0;
        while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
        load = 1'b0;
        check("bp_valid", 32'(out_valid), 1);
        for (int c = 0; c < 3; c++) begin
            load = (c == 1);
            check("bp_hold_data", 32'(sorted_data), 1);
            check("bp_hold_idx", 32'(sorted_idx), 3);
            @(posedge clk); #1;
        end
        load = 1'b0;
        out_ready = 1'b1;
        for (int p = 0; p < N; p++) begin
            check("bp_data", 32'(sorted_data), 32'(tbl[0].ed[p]));
            check("bp_idx", 32'(sorted_idx), 32'(tbl[0].ei[p]));
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("bp_done", 32'(done), 1);
        check("bp_idle", 32'(busy), 0);
        @(posedge clk); #1;

        // Reset during sort phase 2.
        data_in = pk(9, 8, 7, 6); load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_done", 32'(done), 0);
        v = tbl[2];
        run_batch(v, 1'b0);
        @(posedge clk); #1;

        // Top-K with K=2.
        data2 = pk(200, 10, 150, 20); load2 = 1'b1;
        @(posedge clk); #1;
        load2 = 1'b0;
        w = 0;
        while (!valid2 && w < 20) begin @(posedge clk); #1; w++; end
        check("k2_valid0", 32'(valid2), 1);
        check("k2_data0", 32'(sd2), 10);
        check("k2_idx0", 32'(si2), 1);
        @(posedge clk); #1;
        check("k2_valid1", 32'(valid2), 1);
        check("k2_data1", 32'(sd2), 20);
        check("k2_idx1", 32'(si2), 3);
        @(posedge clk); #1;
        check("k2_done", 32'(done2), 1);
        check("k2_valid_end", 32'(valid2), 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("k2_quiet_valid", 32'(valid2), 0);
            check("k2_quiet_done", 32'(done2), 0);
        end

        // Randomized batches; narrow value range on some to force ties.
        for (int t = 0; t < 40; t++) begin
            bit narrow;
            narrow = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N; i++)
                v.din[i] = narrow ? DW'($urandom_range(0, 3)) : DW'($urandom_range(0, 255));
            ref_sort(v.din, v.ed, v.ei);
            v.lat = 0;
            run_batch(v, 1'b1);
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
